cap_code_sequencer: RTL and testbench

CAP_CODE_SEQUENCER -- requirements
Module: cap_code_sequencer

---
 rtl/qcm_ctrl_pkg.sv | 21 ++
 rtl/cycle_timer.sv | 27 ++
 rtl/cap_code_sequencer.sv | 127 ++++++++++++
 tb/tb_cap_code_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/qcm_ctrl_pkg.sv
// Shared constants and FSM state type for the capacitor code sequencer.
package qcm_ctrl_pkg;

    localparam int unsigned DEF_SETTLE_COUNT   = 4;
    localparam int unsigned DEF_DISABLE_CYCLES = 8;
    localparam int unsigned DEF_HOLD_CYCLES    = 16;
    localparam int unsigned CODE_W             = 7;
    localparam int unsigned UPD_W              = 8;

    typedef enum logic [1:0] {
        ST_TRACK,
        ST_DISABLE,
        ST_LOAD,
        ST_HOLD
    } seq_state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Load-and-count-down timer; done is high for the single cycle the count sits at 1.
module cycle_timer #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned RESET_COUNT = 16
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             load,
    input  logic [WIDTH-1:0] length,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= WIDTH'(RESET_COUNT);
        end else if (load) begin
            count <= length;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/cap_code_sequencer.sv
// Qualifies new capacitor states and sequences enable-drop / code-load / hold
// so the tuning codes only ever change while both decoders are disabled.
module cap_code_sequencer
    import qcm_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_COUNT   = DEF_SETTLE_COUNT,
    parameter int unsigned DISABLE_CYCLES = DEF_DISABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [6:0] stateIn,
    input  logic       stateValid,
    input  logic       freeze,
    output logic [6:0] codeSer,
    output logic [6:0] codePar,
    output logic       enableSer,
    output logic       enablePar,
    output logic       busy,
    output logic [7:0] updateCount
);

    localparam int unsigned TW = $clog2(max2(DISABLE_CYCLES, HOLD_CYCLES) + 1);
    localparam int unsigned CW = $clog2(SETTLE_COUNT + 1);

    if (SETTLE_COUNT < 1 || DISABLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("cap_code_sequencer: SETTLE_COUNT, DISABLE_CYCLES and HOLD_CYCLES must be >= 1");
    end

    seq_state_t    state_q, state_d;
    logic [6:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timer_load;
    logic [TW-1:0] timer_len;
    logic          timer_done;
    logic          load_codes;
    logic          track_d;

    // Reset lands in HOLD with the timer preloaded, so enables rise HOLD_CYCLES after release.
    cycle_timer #(
        .WIDTH      (TW),
        .RESET_COUNT(HOLD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .resetN(resetN),
        .load  (timer_load),
        .length(timer_len),
        .done  (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        timer_load = 1'b0;
        timer_len  = TW'(DISABLE_CYCLES);
        load_codes = 1'b0;
        unique case (state_q)
            ST_TRACK: begin
                if (cnt_q == CW'(SETTLE_COUNT) && !freeze) begin
                    state_d    = ST_DISABLE;
                    cnt_d      = '0;
                    timer_load = 1'b1;
                    timer_len  = TW'(DISABLE_CYCLES);
                end else if (freeze) begin
                    cnt_d = '0;
                end else if (stateValid) begin
                    if (stateIn == codeSer) begin
                        cnt_d = '0;
                    end else if (stateIn == cand_q) begin
                        if (cnt_q != CW'(SETTLE_COUNT)) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cand_d = stateIn;
                        cnt_d  = CW'(1);
                    end
                end
            end
            ST_DISABLE: begin
                if (timer_done) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d    = ST_HOLD;
                load_codes = 1'b1;
                timer_load = 1'b1;
                timer_len  = TW'(HOLD_CYCLES);
            end
            ST_HOLD: begin
                if (timer_done) begin
                    state_d = ST_TRACK;
                end
            end
            default: state_d = ST_HOLD;
        endcase
        track_d = (state_d == ST_TRACK);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_HOLD;
            cand_q      <= '0;
            cnt_q       <= '0;
            codeSer     <= '0;
            codePar     <= '0;
            enableSer   <= 1'b0;
            enablePar   <= 1'b0;
            busy        <= 1'b1;
            updateCount <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            enableSer <= track_d;
            enablePar <= track_d;
            busy      <= !track_d;
            if (load_codes) begin
                codeSer     <= cand_q;
                codePar     <= cand_q;
                updateCount <= updateCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cap_code_sequencer.sv
// Bench for cap_code_sequencer: directed scenarios plus random traffic checked
// every cycle against an event-time reference model.
module tb_cap_code_sequencer;

    localparam int S = 4;
    localparam int D = 8;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic [6:0] stateIn = '0;
    logic       stateValid = 1'b0;
    logic       freeze = 1'b0;
    logic [6:0] codeSer, codePar;
    logic       enableSer, enablePar, busy;
    logic [7:0] updateCount;

    always #5 clk = ~clk;

    cap_code_sequencer #(
        .SETTLE_COUNT  (S),
        .DISABLE_CYCLES(D),
        .HOLD_CYCLES   (H)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .stateIn    (stateIn),
        .stateValid (stateValid),
        .freeze     (freeze),
        .codeSer    (codeSer),
        .codePar    (codePar),
        .enableSer  (enableSer),
        .enablePar  (enablePar),
        .busy       (busy),
        .updateCount(updateCount)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: edges counted since reset release, sequence milestones as absolute edge times.
    int t, m_code, m_cand, m_cnt, m_upd, code_at, track_at;
    bit m_track;
    logic [6:0] prev_ser, prev_par;
    logic       prev_en;

    task automatic model_reset();
        t = 0; m_track = 0; m_code = 0; m_cand = 0; m_cnt = 0; m_upd = 0;
        code_at = -1; track_at = H;
    endtask

    task automatic model_step(input bit v, input int s, input bit f);
        t++;
        if (m_track) begin
            if (!f && m_cnt == S) begin
                m_track = 0; m_cnt = 0;
                code_at = t + D + 1;
                track_at = code_at + H;
            end else if (f) begin
                m_cnt = 0;
            end else if (v) begin
                if (s == m_code) m_cnt = 0;
                else if (s == m_cand) m_cnt = (m_cnt + 1 > S) ? S : m_cnt + 1;
                else begin m_cand = s; m_cnt = 1; end
            end
        end else begin
            if (t == code_at) begin m_code = m_cand; m_upd = (m_upd + 1) % 256; end
            if (t == track_at) m_track = 1;
        end
    endtask

    task automatic cycle(input bit v, input logic [6:0] s, input bit f);
        stateValid = v; stateIn = s; freeze = f;
        @(posedge clk); #1;
        model_step(v, int'(s), f);
        check_eq("codeSer", 32'(codeSer), 32'(m_code));
        check_eq("codePar", 32'(codePar), 32'(m_code));
        check_eq("enableSer", 32'(enableSer), 32'(m_track));
        check_eq("enablePar", 32'(enablePar), 32'(m_track));
        check_eq("busy", 32'(busy), 32'(!m_track));
        check_eq("updateCount", 32'(updateCount), 32'(m_upd));
        if (codeSer !== prev_ser || codePar !== prev_par)
            check_eq("enable_at_code_change", 32'(prev_en | enableSer | enablePar), 32'd0);
        prev_ser = codeSer; prev_par = codePar; prev_en = enableSer | enablePar;
        stateValid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 7'($urandom_range(0, 127)), 1'b0);
    endtask

    task automatic pulses(input logic [6:0] val, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, val, 1'b0);
    endtask

    // Called just after a rising edge; releases reset on the following falling edge.
    task automatic do_reset();
        resetN = 1'b0;
        stateValid = 1'b0; freeze = 1'b0;
        #2;
        check_eq("rst_codeSer", 32'(codeSer), 32'd0);
        check_eq("rst_codePar", 32'(codePar), 32'd0);
        check_eq("rst_enableSer", 32'(enableSer), 32'd0);
        check_eq("rst_enablePar", 32'(enablePar), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_updateCount", 32'(updateCount), 32'd0);
        model_reset();
        prev_ser = codeSer; prev_par = codePar; prev_en = 1'b0;
        #2;
        resetN = 1'b1;
    endtask

    initial begin
        logic [6:0] rs;
        #6;
        do_reset();

        // Power-up: hold then enables rise at the 16th edge with code 0.
        idle(20);

        // Plain update to 37.
        pulses(7'd37, 4);
        idle(30);
        check_eq("upd37_code", 32'(codeSer), 32'd37);
        check_eq("upd37_count", 32'(updateCount), 32'd1);

        // Candidate restart: 37,37,12 then 37 x4.
        do_reset();
        idle(18);
        cycle(1'b1, 7'd37, 1'b0); cycle(1'b0, 7'd0, 1'b0);
        cycle(1'b1, 7'd37, 1'b0); cycle(1'b0, 7'd0, 1'b0);
        cycle(1'b1, 7'd12, 1'b0); cycle(1'b0, 7'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin cycle(1'b1, 7'd37, 1'b0); cycle(1'b0, 7'd0, 1'b0); end
        idle(5);
        check_eq("restart_no_update", 32'(updateCount), 32'd0);
        pulses(7'd37, 1);
        idle(30);
        check_eq("restart_code", 32'(codeSer), 32'd37);

        // Freeze blocks qualification; release then four samples update.
        for (int i = 0; i < 6; i++) begin cycle(1'b1, 7'd50, 1'b1); cycle(1'b0, 7'd0, 1'b1); end
        idle(3);
        check_eq("freeze_code", 32'(codeSer), 32'd37);
        pulses(7'd50, 4);
        idle(30);
        check_eq("unfreeze_code", 32'(codeSer), 32'd50);

        // Samples during DISABLE/HOLD are ignored; freeze mid-sequence does not abort.
        pulses(7'd37, 4);
        idle(2);
        pulses(7'd99, 4);
        for (int i = 0; i < 8; i++) cycle(1'b0, 7'd0, 1'b1);
        pulses(7'd99, 4);
        idle(10);
        check_eq("ignored_code", 32'(codeSer), 32'd37);
        pulses(7'd99, 4);
        idle(30);
        check_eq("requal_code", 32'(codeSer), 32'd99);

        // Reset during HOLD of an update to 37.
        do_reset();
        idle(18);
        pulses(7'd37, 4);
        idle(15);
        check_eq("pre_reset_code", 32'(codeSer), 32'd37);
        do_reset();
        idle(20);

        // 256 alternating updates wrap the counter.
        for (int i = 0; i < 256; i++) begin
            pulses((i % 2 == 0) ? 7'd1 : 7'd2, 4);
            idle(28);
        end
        check_eq("wrap_count", 32'(updateCount), 32'd0);
        check_eq("wrap_code", 32'(codeSer), 32'd2);

        // Random traffic.
        rs = 7'd1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) < 3) rs = 7'($urandom_range(0, 3));
                cycle(1'($urandom_range(0, 1)), rs, ($urandom_range(0, 19) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
